// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_arb_pkg                                                  |
// | Description : Shared types and constants for the memory arbiter: the       |
// |               owner encoding of the in-flight access and the byte-to-word  |
// |               address shift.                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    // Which requester owns the access whose read data returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Requesters use byte addresses; the memory is indexed by 32-bit words.
    localparam int WORD_SHIFT = 2;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_starve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arb_starve                                               |
// | Description : Counts consecutive cycles in which a request is pending but  |
// |               not granted. Once the count reaches STARVE_LIMIT the         |
// |               promote flag is raised so the arbiter lets the request win.  |
// | Ports       : clk, rst     - clock, synchronous active-high reset          |
// |               req, gnt     - request and grant of the watched requester    |
// |               promote      - request has been starved long enough          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic promote
);

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve;

    // Saturating counter: any grant or a dropped request restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (gnt || !req) begin
            r_starve <= '0;
        end else if (r_starve != C_LIMIT) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign promote = (r_starve == C_LIMIT);

endmodule : mem_arb_starve
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Shares one single-port, word-indexed memory with 1-cycle     |
// |               read latency between the fetch (if_*) and load/store (d_*)   |
// |               requesters. One access is granted per cycle, fully           |
// |               pipelined; read data is routed to the owner a cycle later.   |
// |               Load/store wins unless fetch has been starved STARVE_LIMIT   |
// |               cycles.                                                      |
// | Ports       : clk, rst                     - clock, sync active-high reset |
// |               if_req/addr/flush, if_gnt/rvalid/rdata - fetch port          |
// |               d_req/we/addr/wdata, d_gnt/rvalid/rdata - load/store port    |
// |               mem_write_en/addr/write_data, mem_read_data - memory side    |
// | Options     : MEM_ARB_PERF_EN adds perf_if_cnt, perf_d_cnt, perf_stall_cnt |
// |               (grant counts and conflict-cycle count, wrap mod 2^32).      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_write_en,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    owner_e            r_owner;
    logic              r_flush;
    logic              w_promote;
    logic [ADDR_W-1:0] w_addr_sel;

    mem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req     (if_req),
        .gnt     (if_gnt),
        .promote (w_promote)
    );

    // Fixed priority to load/store, overridden by a starved fetch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (if_req && (w_promote || !d_req)) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end
    end

    always_comb begin
        w_addr_sel = '0;
        if (if_gnt) begin
            w_addr_sel = if_addr;
        end else if (d_gnt) begin
            w_addr_sel = d_addr;
        end
    end

    assign mem_addr       = 32'(w_addr_sel >> WORD_SHIFT);
    assign mem_write_en   = d_gnt && d_we;
    assign mem_write_data = d_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_flush <= 1'b0;
        end else begin
            r_owner <= if_gnt ? OWN_IF : (d_gnt ? OWN_D : OWN_NONE);
            r_flush <= if_flush && if_gnt;
        end
    end

    // Gating with rst drops the response of an access granted just before a
    // reset, in the reset cycle itself; the owner register clears afterwards.
    // A flush in the response cycle also suppresses the fetch response.
    assign if_rvalid = (r_owner == OWN_IF) && !r_flush && !if_flush && !rst;
    assign d_rvalid  = (r_owner == OWN_D) && !rst;
    assign if_rdata  = mem_read_data;
    assign d_rdata   = mem_read_data;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_cnt    <= '0;
            perf_d_cnt     <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (if_gnt)           perf_if_cnt    <= perf_if_cnt + 32'd1;
            if (d_gnt)            perf_d_cnt     <= perf_d_cnt + 32'd1;
            if (if_req && d_req)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter. A behavioural memory    |
// |               answers the DUT; a reference model predicts grants and the   |
// |               memory drive each cycle and queues the expected response,    |
// |               which is popped and compared in the following cycle.         |
// |               Directed sequences cover the documented scenarios, followed  |
// |               by a random phase. Perf counters are checked when            |
// |               MEM_ARB_PERF_EN is defined.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int MEM_WORDS    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_flush = 1'b0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_write_en;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_if_cnt, perf_d_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_d_cnt     (perf_d_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Behavioural single-port memory: registered read, read-before-write.
    logic [DATA_W-1:0] mem     [MEM_WORDS];
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr[5:0]];
        if (mem_write_en) mem[mem_addr[5:0]] <= mem_write_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        owner_e            owner;
        logic              flush;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t sb_q[$];
    int    m_starve = 0;

    always @(negedge clk) begin
        resp_t             r;
        logic              m_if, m_d, e_ifv, e_dv;
        logic [31:0]       e_addr;
        if (run) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'd0, 64'd1);
            end else begin
                r     = sb_q.pop_front();
                e_ifv = (r.owner == OWN_IF) && !r.flush && !if_flush && !rst;
                e_dv  = (r.owner == OWN_D) && !rst;
                check_eq("if_rvalid", if_rvalid, e_ifv);
                check_eq("d_rvalid", d_rvalid, e_dv);
                if (e_ifv) check_eq("if_rdata", if_rdata, r.data);
                if (e_dv)  check_eq("d_rdata", d_rdata, r.data);
            end

            m_if   = if_req && ((m_starve == STARVE_LIMIT) || !d_req);
            m_d    = d_req && !m_if;
            e_addr = m_if ? (if_addr / 4) : (m_d ? (d_addr / 4) : 32'd0);
            check_eq("if_gnt", if_gnt, m_if);
            check_eq("d_gnt", d_gnt, m_d);
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_write_en", mem_write_en, m_d && d_we);
            if (m_d && d_we) check_eq("mem_write_data", mem_write_data, d_wdata);

            r.owner = rst ? OWN_NONE : (m_if ? OWN_IF : (m_d ? OWN_D : OWN_NONE));
            r.flush = if_flush && m_if;
            r.data  = ref_mem[e_addr[5:0]];
            if (m_d && d_we) ref_mem[e_addr[5:0]] = d_wdata;
            sb_q.push_back(r);

            if (rst || m_if || !if_req)       m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req   = 1'b0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
    endtask

    initial begin
        resp_t init_r;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        init_r.owner = OWN_NONE;
        init_r.flush = 1'b0;
        init_r.data  = '0;
        sb_q.push_back(init_r);

        // Reset
        tick();
        run = 1'b1;
        #2;
        check_eq("reset_if_rvalid", if_rvalid, 1'b0);
        check_eq("reset_d_rvalid", d_rvalid, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10;
        #2;
        check_eq("t1_if_gnt", if_gnt, 1'b1);
        check_eq("t1_mem_addr", mem_addr, 32'd4);
        tick(); idle();
        #2;
        check_eq("t1_if_rvalid", if_rvalid, 1'b1);
        check_eq("t1_if_rdata", if_rdata, 32'hA500_0004);

        // Conflict: load/store wins until fetch is starved for STARVE_LIMIT cycles
        for (int i = 0; i < 6; i++) begin
            tick();
            if_req = 1'b1; if_addr = 32'h14;
            d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h18;
            #2;
            check_eq($sformatf("t2_if_gnt_%0d", i), if_gnt, (i == 4));
            check_eq($sformatf("t2_d_gnt_%0d", i), d_gnt, (i != 4));
        end

        // Store then load at 0x20
        tick(); idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        #2;
        check_eq("t3_store_we", mem_write_en, 1'b1);
        tick();
        d_we = 1'b0;
        #2;
        check_eq("t3_store_ack", d_rvalid, 1'b1);
        check_eq("t3_store_old", d_rdata, 32'hA500_0008);
        tick(); idle();
        #2;
        check_eq("t3_load_valid", d_rvalid, 1'b1);
        check_eq("t3_load_data", d_rdata, 32'hDEAD_BEEF);

        // Flush: registered flush on a granted fetch, d response unaffected
        tick(); d_req = 1'b1; d_addr = 32'h0C;
        tick(); idle(); if_req = 1'b1; if_addr = 32'h08; if_flush = 1'b1;
        #2;
        check_eq("t4_d_rvalid", d_rvalid, 1'b1);
        check_eq("t4_d_rdata", d_rdata, 32'hA500_0003);
        tick(); idle();
        #2;
        check_eq("t4_flushq_if_rvalid", if_rvalid, 1'b0);
        // Flush raised in the response cycle
        tick(); if_req = 1'b1; if_addr = 32'h04;
        tick(); idle(); if_flush = 1'b1;
        #2;
        check_eq("t4_late_flush_if_rvalid", if_rvalid, 1'b0);
        tick(); idle();

        // Reset right after a load grant, with fetch partly starved
        tick(); if_req = 1'b1; if_addr = 32'h28; d_req = 1'b1; d_addr = 32'h24;
        tick();
        tick(); rst = 1'b1;
        #2;
        check_eq("t5_rst_d_rvalid", d_rvalid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            rst = 1'b0;
            #2;
            if (i == 0) check_eq("t5_after_rst_d_rvalid", d_rvalid, 1'b0);
            check_eq($sformatf("t5_starve_cleared_%0d", i), if_gnt, (i == 4));
        end

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            tick(); idle();
            rst      = ($urandom_range(0, 39) == 0);
            if_req   = $urandom_range(0, 1) == 1;
            if_addr  = 32'($urandom_range(0, 255));
            if_flush = ($urandom_range(0, 7) == 0);
            d_req    = $urandom_range(0, 2) != 0;
            d_we     = $urandom_range(0, 1) == 1;
            d_addr   = 32'($urandom_range(0, 255));
            d_wdata  = $urandom;
        end
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;

`ifdef MEM_ARB_PERF_EN
        // 3 IF grants, 2 D grants, 2 conflict cycles
        tick(); if_req = 1'b1; if_addr = 32'h00;
        tick();
        tick(); d_req = 1'b1; d_addr = 32'h04;
        tick();
        tick(); d_req = 1'b0;
        tick(); idle();
        #2;
        check_eq("t6_perf_if", perf_if_cnt, 32'd3);
        check_eq("t6_perf_d", perf_d_cnt, 32'd2);
        check_eq("t6_perf_stall", perf_stall_cnt, 32'd2);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #2;
        check_eq("t6_perf_if_rst", perf_if_cnt, 32'd0);
        check_eq("t6_perf_d_rst", perf_d_cnt, 32'd0);
        check_eq("t6_perf_stall_rst", perf_stall_cnt, 32'd0);
`endif

        tick(); idle();
        tick();
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
